// File: rtl/baccarat_round_ctrl_if.sv
// Signal bundle between the baccarat round controller, the card source and the
// hand registers/scoring logic. The controller attaches through the slave modport.
interface baccarat_round_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             card_valid;
    logic [3:0]       pscore;
    logic [3:0]       dscore;
    logic [3:0]       pcard3;
    logic             load_pcard1;
    logic             load_pcard2;
    logic             load_pcard3;
    logic             load_dcard1;
    logic             load_dcard2;
    logic             load_dcard3;
    logic             clear_hands;
    logic             player_win_light;
    logic             dealer_win_light;
    logic [CNT_W-1:0] player_wins;
    logic [CNT_W-1:0] dealer_wins;
    logic [CNT_W-1:0] ties;
    logic [CNT_W-1:0] round_num;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, card_valid, pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3, clear_hands,
        input  player_win_light, dealer_win_light,
        input  player_wins, dealer_wins, ties, round_num, busy, done, err
    );

    modport slave (
        input  start, card_valid, pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3, clear_hands,
        output player_win_light, dealer_win_light,
        output player_wins, dealer_wins, ties, round_num, busy, done, err
    );
endinterface

// File: rtl/baccarat_round_ctrl.sv
// Multi-round baccarat dealing controller with third-card rules and saturating tallies.
// Optional card-wait timeout is enabled by defining BACCARAT_CARD_TIMEOUT_EN.
module baccarat_round_ctrl #(
    parameter int ROUNDS  = 8,
    parameter int CNT_W   = 8,
    parameter int HOLD    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 slow_clock,
    input  logic                 reset,
    baccarat_round_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, CLR, P1, D1, P2, D2, DECIDE, P3, BWAIT, D3, RESULT, SHOW, DONE
    } state_t;

    localparam int HW = $clog2(HOLD + 1);

    state_t           state, state_nxt;
    logic [HW-1:0]    hold_cnt;
    logic [CNT_W-1:0] player_wins, dealer_wins, ties, round_num;
    logic             player_light, dealer_light;
    logic             start_acc, is_deal, hold_done, last_round, timeout, err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic banker_draw(input logic [3:0] b, input logic [3:0] c3);
        case (b)
            4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
            4'd3:             banker_draw = (c3 != 4'd8);
            4'd4:             banker_draw = (c3 >= 4'd2) && (c3 <= 4'd7);
            4'd5:             banker_draw = (c3 >= 4'd4) && (c3 <= 4'd7);
            4'd6:             banker_draw = (c3 >= 4'd6) && (c3 <= 4'd7);
            default:          banker_draw = 1'b0;
        endcase
    endfunction

    assign start_acc  = bus.start && ((state == IDLE) || (state == DONE));
    assign is_deal    = (state == P1) || (state == D1) || (state == P2) ||
                        (state == D2) || (state == P3) || (state == D3);
    assign hold_done  = (hold_cnt == HW'(HOLD - 1));
    assign last_round = (round_num == CNT_W'(ROUNDS - 1));

    // Parameter combinations outside this range are not supported.
    if (ROUNDS < 1 || HOLD < 1 || TIMEOUT < 1) begin : g_unsupported_params
    end

`ifdef BACCARAT_CARD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    assign timeout = is_deal && !bus.card_valid && (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= (is_deal && !bus.card_valid && !timeout) ? wait_cnt + TW'(1) : '0;
            if (timeout)        err <= 1'b1;
            else if (start_acc) err <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge slow_clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (bus.start) state_nxt = CLR;
            CLR:    state_nxt = P1;
            P1:     if (bus.card_valid) state_nxt = D1;
            D1:     if (bus.card_valid) state_nxt = P2;
            P2:     if (bus.card_valid) state_nxt = D2;
            D2:     if (bus.card_valid) state_nxt = DECIDE;
            DECIDE: begin
                if (bus.pscore >= 4'd8 || bus.dscore >= 4'd8) state_nxt = RESULT;
                else if (bus.pscore <= 4'd5)                  state_nxt = P3;
                else if (bus.dscore <= 4'd5)                  state_nxt = D3;
                else                                          state_nxt = RESULT;
            end
            P3:     if (bus.card_valid) state_nxt = BWAIT;
            BWAIT:  state_nxt = banker_draw(bus.dscore, bus.pcard3) ? D3 : RESULT;
            D3:     if (bus.card_valid) state_nxt = RESULT;
            RESULT: state_nxt = SHOW;
            SHOW:   if (hold_done) state_nxt = last_round ? DONE : CLR;
            DONE:   if (bus.start) state_nxt = CLR;
            default: state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end

    always_comb begin
        bus.load_pcard1 = (state == P1) && bus.card_valid;
        bus.load_dcard1 = (state == D1) && bus.card_valid;
        bus.load_pcard2 = (state == P2) && bus.card_valid;
        bus.load_dcard2 = (state == D2) && bus.card_valid;
        bus.load_pcard3 = (state == P3) && bus.card_valid;
        bus.load_dcard3 = (state == D3) && bus.card_valid;
        bus.clear_hands = (state == CLR);
        bus.busy        = (state != IDLE) && (state != DONE);
        bus.done        = (state == DONE);
    end

    // Lights, tallies, round index and the SHOW hold counter.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            player_light <= 1'b0;
            dealer_light <= 1'b0;
            player_wins  <= '0;
            dealer_wins  <= '0;
            ties         <= '0;
            round_num    <= '0;
            hold_cnt     <= '0;
        end else begin
            if (start_acc) begin
                player_wins <= '0;
                dealer_wins <= '0;
                ties        <= '0;
                round_num   <= '0;
            end
            if (state == CLR || timeout) begin
                player_light <= 1'b0;
                dealer_light <= 1'b0;
            end
            if (state == RESULT) begin
                player_light <= (bus.pscore >= bus.dscore);
                dealer_light <= (bus.dscore >= bus.pscore);
                if (bus.pscore > bus.dscore)      player_wins <= sat_inc(player_wins);
                else if (bus.pscore < bus.dscore) dealer_wins <= sat_inc(dealer_wins);
                else                              ties        <= sat_inc(ties);
            end
            hold_cnt <= (state == SHOW) ? hold_cnt + HW'(1) : '0;
            if (state == SHOW && hold_done && !last_round) round_num <= round_num + CNT_W'(1);
        end
    end

    assign bus.player_win_light = player_light;
    assign bus.dealer_win_light = dealer_light;
    assign bus.player_wins      = player_wins;
    assign bus.dealer_wins      = dealer_wins;
    assign bus.ties             = ties;
    assign bus.round_num        = round_num;
    assign bus.err              = err;
endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Scoreboard bench for baccarat_round_ctrl: a baccarat rules model predicts load order and
// round results for random and directed card streams; a monitor compares what the DUT shows.
`timescale 1ns/1ps
module tb_baccarat_round_ctrl;
    localparam int ROUNDS  = 4;
    localparam int CNT_W   = 2;
    localparam int HOLD    = 4;
    localparam int TIMEOUT = 16;
    localparam int MAXV    = (1 << CNT_W) - 1;

    typedef struct {
        int lights;
        int pw;
        int dw;
        int ti;
        int rnd;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    baccarat_round_ctrl_if #(.CNT_W(CNT_W)) bus ();

    baccarat_round_ctrl #(
        .ROUNDS(ROUNDS), .CNT_W(CNT_W), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .slow_clock(clk),
        .reset(reset),
        .bus(bus)
    );

    int   exp_load_q[$];
    res_t exp_res_q[$];
    res_t last_res;
    int   stream[$];
    int   rc[6];
    int   m_pw, m_dw, m_ti;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   valid_pct = 70;
    int   cyc = 0;
    int   card_idx = 0;
    int   pc1 = 0, pc2 = 0, pc3 = 0, dc1 = 0, dc2 = 0, dc3 = 0;
    int   prev_lights = 0;
    bit   prev_done = 1'b0;
    int   res_cyc = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int cur_card();
        return (card_idx < stream.size()) ? stream[card_idx] : 0;
    endfunction

    // External hand registers and scoring logic, fed from the card stream.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.clear_hands) begin
            pc1 <= 0; pc2 <= 0; pc3 <= 0; dc1 <= 0; dc2 <= 0; dc3 <= 0;
        end
        if (bus.load_pcard1) pc1 <= cur_card();
        if (bus.load_pcard2) pc2 <= cur_card();
        if (bus.load_pcard3) pc3 <= cur_card();
        if (bus.load_dcard1) dc1 <= cur_card();
        if (bus.load_dcard2) dc2 <= cur_card();
        if (bus.load_dcard3) dc3 <= cur_card();
        if (bus.load_pcard1 || bus.load_pcard2 || bus.load_pcard3 ||
            bus.load_dcard1 || bus.load_dcard2 || bus.load_dcard3)
            card_idx <= card_idx + 1;
    end

    assign bus.pscore = 4'((pc1 + pc2 + pc3) % 10);
    assign bus.dscore = 4'((dc1 + dc2 + dc3) % 10);
    assign bus.pcard3 = 4'(pc3);

    initial begin
        bus.card_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.card_valid = ($urandom_range(0, 99) < valid_pct);
        end
    end

    // Baccarat rules on the round's candidate cards rc[]; appends the consumed cards
    // to the stream and queues the expected load codes (p1,p2,p3,d1,d2,d3 = 0..5) and result.
    task automatic model_round(input int rnd);
        int   p, b, n, p3;
        bit   bdraw;
        res_t e;
        p = (rc[0] + rc[2]) % 10;
        b = (rc[1] + rc[3]) % 10;
        n = 4;
        exp_load_q.push_back(0); exp_load_q.push_back(3);
        exp_load_q.push_back(1); exp_load_q.push_back(4);
        if (p < 8 && b < 8) begin
            if (p <= 5) begin
                p3 = rc[4];
                p  = (p + p3) % 10;
                n  = 5;
                exp_load_q.push_back(2);
                bdraw = (b <= 2) || (b == 3 && p3 != 8) || (b == 4 && p3 >= 2 && p3 <= 7) ||
                        (b == 5 && p3 >= 4 && p3 <= 7) || (b == 6 && p3 >= 6 && p3 <= 7);
            end else begin
                bdraw = (b <= 5);
            end
            if (bdraw) begin
                b = (b + rc[n]) % 10;
                n++;
                exp_load_q.push_back(5);
            end
        end
        for (int i = 0; i < n; i++) stream.push_back(rc[i]);
        if (p > b)      m_pw = (m_pw < MAXV) ? m_pw + 1 : m_pw;
        else if (p < b) m_dw = (m_dw < MAXV) ? m_dw + 1 : m_dw;
        else            m_ti = (m_ti < MAXV) ? m_ti + 1 : m_ti;
        e.lights = ((p >= b) ? 2 : 0) + ((b >= p) ? 1 : 0);
        e.pw = m_pw; e.dw = m_dw; e.ti = m_ti; e.rnd = rnd;
        exp_res_q.push_back(e);
    endtask

    task automatic set_rc(input int a, input int b, input int c, input int d,
                          input int e, input int f);
        rc[0] = a; rc[1] = b; rc[2] = c; rc[3] = d; rc[4] = e; rc[5] = f;
    endtask

    // Monitor: pops expectations whenever the DUT loads a card, shows a result or finishes.
    initial begin
        logic [5:0] ld;
        int         code, lights;
        res_t       e;
        forever begin
            @(negedge clk);
            ld = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                  bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};
            lights = {30'd0, bus.player_win_light, bus.dealer_win_light};
            if (mon_en) begin
                check("loads_exclusive", int'($countones(ld) <= 1), 1);
                if ($countones(ld) == 1) begin
                    code = 0;
                    for (int i = 0; i < 6; i++) if (ld[i]) code = i;
                    if (exp_load_q.size() == 0) check("load_unexpected", code, -1);
                    else                        check("load_order", code, exp_load_q.pop_front());
                    check("load_needs_valid", int'(bus.card_valid), 1);
                end
                if (lights != 0 && prev_lights == 0) begin
                    if (exp_res_q.size() == 0) begin
                        check("result_unexpected", lights, 0);
                    end else begin
                        e = exp_res_q.pop_front();
                        last_res = e;
                        check("lights", lights, e.lights);
                        check("player_wins", int'(bus.player_wins), e.pw);
                        check("dealer_wins", int'(bus.dealer_wins), e.dw);
                        check("ties", int'(bus.ties), e.ti);
                        check("round_num", int'(bus.round_num), e.rnd);
                    end
                    res_cyc = cyc;
                end
                if (bus.done && !prev_done) begin
                    check("done_after_hold", cyc - res_cyc, HOLD);
                    check("done_busy", int'(bus.busy), 0);
                    check("done_dealer_wins", int'(bus.dealer_wins), last_res.dw);
                    check("done_round_num", int'(bus.round_num), ROUNDS - 1);
                end
            end
            prev_lights = lights;
            prev_done   = bus.done;
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_err"}, int'(bus.err), 0);
        check({tag, "_lights"}, int'({bus.player_win_light, bus.dealer_win_light}), 0);
        check({tag, "_clear"}, int'(bus.clear_hands), 0);
        check({tag, "_loads"}, int'({bus.load_pcard1, bus.load_pcard2, bus.load_pcard3,
                                      bus.load_dcard1, bus.load_dcard2, bus.load_dcard3}), 0);
        check({tag, "_round"}, int'(bus.round_num), 0);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_tallies", int'(bus.player_wins) + int'(bus.dealer_wins) + int'(bus.ties), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Sessions: 0 random, 1 directed rule cases, 2 dealer wins to saturation, 3-4 random.
        for (int s = 0; s < 5; s++) begin
            m_pw = 0; m_dw = 0; m_ti = 0;
            for (int r = 0; r < ROUNDS; r++) begin
                if (s == 1) begin
                    case (r)
                        0:       set_rc(4, 1, 4, 2, 0, 0);
                        1:       set_rc(2, 1, 2, 2, 8, 0);
                        2:       set_rc(2, 1, 2, 2, 5, 1);
                        default: set_rc(3, 2, 3, 3, 1, 0);
                    endcase
                end else if (s == 2) begin
                    set_rc(0, 0, 0, 9, 0, 0);
                end else begin
                    for (int i = 0; i < 6; i++) rc[i] = $urandom_range(0, 9);
                end
                model_round(r);
            end
            valid_pct = (s == 4) ? 100 : 70;
            mon_en = 1'b1;
            pulse_start();
            n = 0;
            while (!bus.done && n < 3000) begin
                @(negedge clk);
                n++;
            end
            check("session_done_reached", int'(bus.done), 1);
            if (s == 2) check("dealer_wins_saturated", int'(bus.dealer_wins), MAXV);
        end
        @(negedge clk);
        mon_en = 1'b0;
        check("exp_loads_left", exp_load_q.size(), 0);
        check("exp_results_left", exp_res_q.size(), 0);

        // Reset while dealing D1.
        valid_pct = 100;
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.load_pcard1 && n < 50);
        check("reached_p1_load", int'(bus.load_pcard1), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("busy_in_d1", int'(bus.busy), 1);
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Card source stalls in P1.
        valid_pct = 0;
        repeat (2) @(posedge clk);
        #1;
        pulse_start();
        repeat (TIMEOUT + 8) @(posedge clk);
        @(negedge clk);
`ifdef BACCARAT_CARD_TIMEOUT_EN
        check("timeout_busy", int'(bus.busy), 0);
        check("timeout_err", int'(bus.err), 1);
        check("timeout_done", int'(bus.done), 0);
        valid_pct = 100;
        @(posedge clk);
        #1;
        pulse_start();
        @(negedge clk);
        check("err_cleared_by_start", int'(bus.err), 0);
`else
        check("stall_busy", int'(bus.busy), 1);
        check("stall_err", int'(bus.err), 0);
        check("stall_no_load", int'(bus.load_pcard1), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
